// File: rtl/key_pkg.sv
// Shared keypad types and constants for the debouncer and the lock top.
// Bit map: bits 0..8 = digits 1..9, bit 9 = '*', bit 10 = '0', bit 11 = '#'.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } key_state_t;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam int BIT_STAR = 9;
    localparam int BIT_ZERO = 10;
    localparam int BIT_HASH = 11;

    function automatic logic [3:0] bit_code(input int idx);
        if (idx == BIT_STAR)
            return KEY_STAR;
        else if (idx == BIT_ZERO)
            return 4'd0;
        else if (idx == BIT_HASH)
            return KEY_HASH;
        else
            return 4'(idx + 1);
    endfunction

endpackage

// File: rtl/key_encoder.sv
// Combinational keypad encoder: 12-bit key lines to 4-bit key code.
// o_code is only meaningful while o_is_onehot is high.
module key_encoder
    import key_pkg::*;
(
    input  logic [11:0] i_key,
    output logic [3:0]  o_code,
    output logic        o_is_onehot
);

    always_comb begin
        o_code = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (i_key[i])
                o_code = bit_code(i);
        end
    end

    assign o_is_onehot = (i_key != 12'd0) &&
                         ((i_key & (i_key - 12'd1)) == 12'd0);

endmodule

// File: rtl/key_debounce.sv
// Keypad debouncer: accepts one stable one-hot key and emits Key/key_code/key_strobe.
// Optional auto-repeat of key_strobe while held is enabled by macro KEY_REPEAT_EN.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20,
    parameter int REPEAT_DLY   = 200,
    parameter int REPEAT_PER   = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] key_raw,
    output logic [11:0] Key,
    output logic        key_strobe,
    output logic [3:0]  key_code
);

    // 0 and 1 both mean acceptance on the very next edge
    localparam logic [15:0] LP_THR =
        (DEBOUNCE_CYC <= 1) ? 16'd0 : 16'(DEBOUNCE_CYC - 1);

    key_state_t  r_state;
    logic [11:0] r_sample;
    logic [15:0] r_cnt;

    logic [3:0]  w_code;
    logic        w_onehot;
    logic [15:0] w_cnt_inc;

    key_encoder u_enc (
        .i_key       (key_raw),
        .o_code      (w_code),
        .o_is_onehot (w_onehot)
    );

    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

`ifdef KEY_REPEAT_EN
    localparam logic [15:0] LP_RDLY = 16'(REPEAT_DLY);
    localparam logic [15:0] LP_RPER = 16'(REPEAT_PER);

    logic [15:0] r_rpt;
    logic        r_rpt_on;
    logic [15:0] w_rpt_nxt;
    logic        w_rpt_hit;

    assign w_rpt_nxt = (r_rpt == 16'hFFFF) ? r_rpt : r_rpt + 16'd1;
    assign w_rpt_hit = (w_rpt_nxt == (r_rpt_on ? LP_RPER : LP_RDLY));
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^{16'(REPEAT_DLY), 16'(REPEAT_PER)};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sample   <= 12'd0;
            r_cnt      <= 16'd0;
            Key        <= 12'd0;
            key_code   <= 4'd0;
            key_strobe <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rpt      <= 16'd0;
            r_rpt_on   <= 1'b0;
`endif
        end else begin
            key_strobe <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_onehot) begin
                        r_state  <= DEBOUNCE;
                        r_sample <= key_raw;
                        r_cnt    <= 16'd0;
                    end
                end
                DEBOUNCE: begin
                    if (key_raw != r_sample) begin
                        r_state <= IDLE;
                    end else if (r_cnt >= LP_THR) begin
                        r_state    <= PRESSED;
                        Key        <= r_sample;
                        key_code   <= w_code;
                        key_strobe <= 1'b1;
`ifdef KEY_REPEAT_EN
                        r_rpt      <= 16'd0;
                        r_rpt_on   <= 1'b0;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (key_raw != r_sample) begin
                        r_state  <= RELEASE;
                        Key      <= 12'd0;
                        key_code <= 4'd0;
                        r_cnt    <= 16'd0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (w_rpt_hit) begin
                        key_strobe <= 1'b1;
                        r_rpt      <= 16'd0;
                        r_rpt_on   <= 1'b1;
                    end else begin
                        r_rpt <= w_rpt_nxt;
                    end
`endif
                end
                RELEASE: begin
                    // any activity restarts the all-released window
                    if (key_raw != 12'd0)
                        r_cnt <= 16'd0;
                    else if (r_cnt >= LP_THR)
                        r_state <= IDLE;
                    else
                        r_cnt <= w_cnt_inc;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (DEBOUNCE_CYC=4, REPEAT_DLY=8, REPEAT_PER=4).
// Directed scenarios plus random key segments against a run-length reference model.
module tb_key_debounce;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] key_raw = 12'd0;
    logic [11:0] Key;
    logic        key_strobe;
    logic [3:0]  key_code;

    int checks   = 0;
    int failures = 0;

    int code_tbl [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    // model: 0 waiting, 1 stable run, 2 held, 3 releasing
    int          m_mode = 0;
    logic [11:0] m_val  = 12'd0;
    int          m_len  = 0;
    int          m_hold = 0;
    int          m_zero = 0;

    logic [11:0] e_key  = 12'd0;
    logic        e_str  = 1'b0;
    logic [3:0]  e_code = 4'd0;

    key_debounce #(
        .DEBOUNCE_CYC (D),
        .REPEAT_DLY   (RD),
        .REPEAT_PER   (RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_raw    (key_raw),
        .Key        (Key),
        .key_strobe (key_strobe),
        .key_code   (key_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input logic [11:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 12; i++)
            if (k[i]) c = 4'(code_tbl[i]);
        return c;
    endfunction

    task automatic model(input logic [11:0] k, input logic rst);
        e_str = 1'b0;
        if (rst) begin
            m_mode = 0;
            e_key  = 12'd0;
            e_code = 4'd0;
        end else begin
            case (m_mode)
                0: if ($countones(k) == 1) begin
                    m_val  = k;
                    m_len  = 1;
                    m_mode = 1;
                end
                1: if (k != m_val) begin
                    m_mode = 0;
                end else begin
                    m_len++;
                    if (m_len == D + 1) begin
                        m_mode = 2;
                        m_hold = 0;
                        e_key  = m_val;
                        e_code = code_of(m_val);
                        e_str  = 1'b1;
                    end
                end
                2: if (k != m_val) begin
                    m_mode = 3;
                    m_zero = 0;
                    e_key  = 12'd0;
                    e_code = 4'd0;
                end else begin
                    m_hold++;
`ifdef KEY_REPEAT_EN
                    if (m_hold == RD ||
                        (m_hold > RD && (m_hold - RD) % RP == 0))
                        e_str = 1'b1;
`endif
                end
                default: if (k == 12'd0) begin
                    m_zero++;
                    if (m_zero == D) m_mode = 0;
                end else begin
                    m_zero = 0;
                end
            endcase
        end
    endtask

    task automatic step(input logic [11:0] k, input logic rst);
        key_raw = k;
        reset   = rst;
        @(posedge clock);
        model(k, rst);
        #1;
        chk("key",    32'(Key),        32'(e_key));
        chk("strobe", 32'(key_strobe), 32'(e_str));
        chk("code",   32'(key_code),   32'(e_code));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(12'd0, 1'b0);
    endtask

    initial begin
        int ns;
        int pos;
        int nz;
        int seg;
        int len;
        int b1;
        int b2;
        logic [11:0] k;
        logic        r;

        // reset state
        step(12'h004, 1'b1);
        chk("rst_key",    32'(Key),        32'h0);
        chk("rst_strobe", 32'(key_strobe), 32'h0);
        chk("rst_code",   32'(key_code),   32'h0);
        step(12'd0, 1'b1);
        idle_steps(2);

        // digit 2 held 10 cycles, then released
        ns = 0; pos = -1;
        for (int i = 0; i < 10; i++) begin
            step(12'h002, 1'b0);
            if (key_strobe) begin
                ns++;
                if (pos < 0) pos = i;
            end
        end
        chk("d2_nstrobe", ns, 1);
        chk("d2_pos",     pos, 4);
        chk("d2_key",     32'(Key), 32'h002);
        chk("d2_code",    32'(key_code), 32'd2);
        step(12'd0, 1'b0);
        chk("d2_release", 32'(Key), 32'h0);
        idle_steps(5);

        // bounce on digit 4
        ns = 0; pos = -1;
        step(12'h008, 1'b0);
        ns += int'(key_strobe);
        step(12'h008, 1'b0);
        ns += int'(key_strobe);
        step(12'h000, 1'b0);
        ns += int'(key_strobe);
        for (int i = 0; i < 10; i++) begin
            step(12'h008, 1'b0);
            if (key_strobe) begin
                ns++;
                if (pos < 0) pos = i;
            end
        end
        chk("bnc_nstrobe", ns, 1);
        chk("bnc_pos",     pos, 4);
        chk("bnc_code",    32'(key_code), 32'd4);
        idle_steps(6);

        // two keys at once are never accepted
        ns = 0; nz = 0;
        for (int i = 0; i < 20; i++) begin
            step(12'h201, 1'b0);
            ns += int'(key_strobe);
            nz += int'(Key != 12'd0);
        end
        chk("multi_nstrobe", ns, 0);
        chk("multi_nkey",    nz, 0);
        idle_steps(2);

        // reset in the middle of debouncing '#'
        ns = 0; pos = -1;
        step(12'h800, 1'b0);
        step(12'h800, 1'b0);
        ns += int'(key_strobe);
        step(12'h800, 1'b1);
        ns += int'(key_strobe);
        chk("rmid_nostrobe", ns, 0);
        for (int i = 0; i < 10; i++) begin
            step(12'h800, 1'b0);
            if (key_strobe) begin
                ns++;
                if (pos < 0) pos = i;
            end
        end
        chk("rmid_nstrobe", ns, 1);
        chk("rmid_pos",     pos, 4);
        chk("rmid_code",    32'(key_code), 32'd11);
        idle_steps(6);

`ifdef KEY_REPEAT_EN
        // auto-repeat on digit 0
        ns = 0;
        for (int i = 0; i < 26; i++) begin
            step(12'h400, 1'b0);
            if (key_strobe) ns++;
        end
        chk("rpt_nstrobe", ns, 5);
        chk("rpt_code",    32'(key_code), 32'd0);
        chk("rpt_key",     32'(Key), 32'h400);
        idle_steps(6);
`endif

        // random key segments with occasional resets
        for (seg = 0; seg < 150; seg++) begin
            b1  = int'($urandom_range(0, 11));
            b2  = (b1 + 1 + int'($urandom_range(0, 10))) % 12;
            len = int'($urandom_range(1, 12));
            case ($urandom_range(0, 9))
                0, 1:    k = 12'd0;
                2:       k = (12'd1 << b1) | (12'd1 << b2);
                default: k = 12'd1 << b1;
            endcase
            for (int i = 0; i < len; i++) begin
                r = ($urandom_range(0, 79) == 0);
                step(k, r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
